// File: rtl/iq_tx_interp_pkg.sv
// iq_tx_interp_pkg
//   Shared definitions for the transmit IQ CIC interpolator.
//   cic_width : internal CIC register width W = in_w + stages * cnt_w.
//   saturate  : clamps a sign-extended value to a signed out_w-bit range.
//               The value is carried at SAT_MAX_WIDTH bits, so W must not
//               exceed SAT_MAX_WIDTH.
package iq_tx_interp_pkg;

    localparam int unsigned SAT_MAX_WIDTH = 64;

    function automatic int unsigned cic_width(input int unsigned in_w,
                                              input int unsigned stages,
                                              input int unsigned cnt_w);
        return in_w + stages * cnt_w;
    endfunction

    function automatic logic signed [SAT_MAX_WIDTH-1:0] saturate(
        input logic signed [SAT_MAX_WIDTH-1:0] v,
        input int unsigned                     out_w
    );
        logic signed [SAT_MAX_WIDTH-1:0] hi;
        logic signed [SAT_MAX_WIDTH-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/cic_interp_lane.sv
// cic_interp_lane
//   One channel of the CIC interpolator: input capture, comb chain,
//   zero-stuff register, integrator chain, gain shift and saturation.
//   Ports:
//     clk_in    : high-rate clock
//     RST       : synchronous active-high reset
//     accept    : high on request cycles; din is consumed on this edge
//     din_valid : din holds a real sample (otherwise a zero is injected)
//     din       : signed input sample
//     dout      : registered, saturated interpolated output
module cic_interp_lane
    import iq_tx_interp_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 12,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned STAGES       = 3,
    parameter int unsigned GAIN_SHIFT   = 4,
    parameter int unsigned W            = cic_width(12, 3, 8)
) (
    input  logic                           clk_in,
    input  logic                           RST,
    input  logic                           accept,
    input  logic                           din_valid,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic signed [OUTPUT_WIDTH-1:0] dout
);

    // The accepted sample is registered first; the comb chain then runs
    // from x_r on the cycle after the accept edge (acc_r marks that cycle).
    logic signed [W-1:0] x_r;
    logic                acc_r;
    logic signed [W-1:0] c     [STAGES+1];
    logic signed [W-1:0] d     [STAGES];
    logic signed [W-1:0] integ [STAGES];
    logic signed [W-1:0] z;

    always_comb begin
        c[0] = x_r;
        for (int unsigned k = 1; k <= STAGES; k++)
            c[k] = c[k-1] - d[k-1];
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            x_r   <= '0;
            acc_r <= 1'b0;
            z     <= '0;
            dout  <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                d[k]     <= '0;
                integ[k] <= '0;
            end
        end else begin
            acc_r <= accept;
            if (accept)
                x_r <= din_valid ? {{(W-INPUT_WIDTH){din[INPUT_WIDTH-1]}}, din} : '0;
            if (acc_r)
                for (int unsigned k = 0; k < STAGES; k++)
                    d[k] <= c[k];
            // Zero-stuffing: only comb-update cycles feed the integrators.
            z <= acc_r ? c[STAGES] : '0;
            integ[0] <= integ[0] + z;
            for (int unsigned k = 1; k < STAGES; k++)
                integ[k] <= integ[k] + integ[k-1];
            dout <= OUTPUT_WIDTH'(saturate(64'(integ[STAGES-1] >>> GAIN_SHIFT),
                                           OUTPUT_WIDTH));
        end
    end

endmodule

// File: rtl/iq_tx_interp.sv
// iq_tx_interp
//   Transmit-side IQ CIC interpolator; upsamples I/Q by runtime ratio N.
//   Ports:
//     clk_in    : high-rate sample clock
//     RST       : synchronous active-high reset
//     N         : interpolation ratio (0 behaves as 1), latched at wrap
//     I_IN/Q_IN : signed low-rate input samples
//     in_valid  : input sample present
//     in_ready  : one-cycle request strobe every N_lat clocks
//     I_OUT/Q_OUT : interpolated, saturated outputs
//     out_valid : sticky, set STAGES+2 cycles after the first accept
//     underflow : sticky, set when a request cycle has no valid sample
module iq_tx_interp
    import iq_tx_interp_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned INPUT_WIDTH  = 12,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned STAGES       = 3,
    parameter int unsigned GAIN_SHIFT   = 4
) (
    input  logic                           clk_in,
    input  logic                           RST,
    input  logic [CNT_WIDTH-1:0]           N,
    input  logic signed [INPUT_WIDTH-1:0]  I_IN,
    input  logic signed [INPUT_WIDTH-1:0]  Q_IN,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic signed [OUTPUT_WIDTH-1:0] I_OUT,
    output logic signed [OUTPUT_WIDTH-1:0] Q_OUT,
    output logic                           out_valid,
    output logic                           underflow
);

    localparam int unsigned W = cic_width(INPUT_WIDTH, STAGES, CNT_WIDTH);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] n_lat;
    logic [CNT_WIDTH-1:0] n_eff;
    logic [STAGES+2:0]    vpipe;

    assign n_eff     = (N == '0) ? CNT_WIDTH'(1) : N;
    assign in_ready  = (cnt == '0) && !RST;
    assign out_valid = vpipe[STAGES+2];

    always_ff @(posedge clk_in) begin
        if (RST) begin
            cnt       <= '0;
            n_lat     <= n_eff;
            underflow <= 1'b0;
            vpipe     <= '0;
        end else begin
            // N is only sampled when the counter is about to return to 0.
            if (cnt == n_lat - CNT_WIDTH'(1)) begin
                cnt   <= '0;
                n_lat <= n_eff;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            if (in_ready && !in_valid)
                underflow <= 1'b1;
            // Bit 0 is a sticky "accepted once" flag; the rest delay it.
            vpipe <= {vpipe[STAGES+1:0], vpipe[0] | in_ready};
        end
    end

    cic_interp_lane #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .STAGES       (STAGES),
        .GAIN_SHIFT   (GAIN_SHIFT),
        .W            (W)
    ) u_lane_i (
        .clk_in    (clk_in),
        .RST       (RST),
        .accept    (in_ready),
        .din_valid (in_valid),
        .din       (I_IN),
        .dout      (I_OUT)
    );

    cic_interp_lane #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .STAGES       (STAGES),
        .GAIN_SHIFT   (GAIN_SHIFT),
        .W            (W)
    ) u_lane_q (
        .clk_in    (clk_in),
        .RST       (RST),
        .accept    (in_ready),
        .din_valid (in_valid),
        .din       (Q_IN),
        .dout      (Q_OUT)
    );

endmodule

// File: tb/tb_iq_tx_interp.sv
// tb_iq_tx_interp
//   Directed bench for iq_tx_interp: reset state, DC gain, impulse response,
//   underflow, N relatch, N=0, mid-stream reset, and saturation (second
//   instance with GAIN_SHIFT=0).
module tb_iq_tx_interp;

    logic              clk_in = 1'b0;
    logic              RST = 1'b1;
    logic [7:0]        N = 8'd4;
    logic signed [11:0] I_IN = '0, Q_IN = '0;
    logic signed [11:0] I_IN_s = '0, Q_IN_s = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, out_valid, underflow;
    logic signed [11:0] I_OUT, Q_OUT;
    logic              in_ready_s, out_valid_s, underflow_s;
    logic signed [11:0] I_OUT_s, Q_OUT_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    iq_tx_interp #(
        .CNT_WIDTH (8), .INPUT_WIDTH (12), .OUTPUT_WIDTH (12),
        .STAGES (3), .GAIN_SHIFT (4)
    ) dut (
        .clk_in (clk_in), .RST (RST), .N (N), .I_IN (I_IN), .Q_IN (Q_IN),
        .in_valid (in_valid), .in_ready (in_ready), .I_OUT (I_OUT),
        .Q_OUT (Q_OUT), .out_valid (out_valid), .underflow (underflow)
    );

    iq_tx_interp #(
        .CNT_WIDTH (8), .INPUT_WIDTH (12), .OUTPUT_WIDTH (12),
        .STAGES (3), .GAIN_SHIFT (0)
    ) dut_s (
        .clk_in (clk_in), .RST (RST), .N (N), .I_IN (I_IN_s), .Q_IN (Q_IN_s),
        .in_valid (in_valid), .in_ready (in_ready_s), .I_OUT (I_OUT_s),
        .Q_OUT (Q_OUT_s), .out_valid (out_valid_s), .underflow (underflow_s)
    );

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int imp [12];
        imp = '{0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};

        // Reset state
        cyc(); cyc();
        chk("rst_i_out", I_OUT, 0);
        chk("rst_q_out", Q_OUT, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_in_ready", in_ready, 0);

        // DC: N=4, I=100, Q=-100
        RST = 1'b0; in_valid = 1'b1; I_IN = 12'sd100; Q_IN = -12'sd100;
        #1;
        chk("dc_ready_0", in_ready, 1);
        for (int k = 1; k <= 24; k++) begin
            cyc();
            chk($sformatf("dc_ready_%0d", k), in_ready, (k % 4) == 0);
            if (k == 5) chk("dc_out_valid_early", out_valid, 0);
            if (k == 6) chk("dc_out_valid", out_valid, 1);
        end
        chk("dc_i_out", I_OUT, 100);
        chk("dc_q_out", Q_OUT, -100);
        chk("dc_underflow", underflow, 0);

        // Underflow: one request cycle without a sample (cnt is 0 here)
        in_valid = 1'b0;
        cyc();
        in_valid = 1'b1;
        chk("uf_set", underflow, 1);
        for (int k = 2; k <= 30; k++) begin
            cyc();
            if (k == 5) chk("uf_i_before_dip", I_OUT, 100);
            if (k == 6) chk("uf_i_dip1", I_OUT, 93);
            if (k == 6) chk("uf_q_dip1", Q_OUT, -94);
            if (k == 7) chk("uf_i_dip2", I_OUT, 81);
        end
        chk("uf_i_recovered", I_OUT, 100);
        chk("uf_sticky", underflow, 1);

        // Mid-stream reset
        RST = 1'b1;
        #1;
        chk("mrst_ready_in_rst", in_ready, 0);
        cyc();
        chk("mrst_i_out", I_OUT, 0);
        chk("mrst_q_out", Q_OUT, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_underflow", underflow, 0);
        RST = 1'b0;
        #1;
        chk("mrst_ready_after", in_ready, 1);

        // Impulse: I=16 once, then zeros
        I_IN = 12'sd16; Q_IN = '0;
        cyc();
        I_IN = '0;
        for (int k = 2; k <= 16; k++) begin
            cyc();
            if (k >= 5) chk($sformatf("imp_i_%0d", k), I_OUT, imp[k-5]);
            if (k == 10) chk("imp_q_zero", Q_OUT, 0);
        end

        // N change 4 -> 2 mid-period, then N=0
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 4) chk("nchg_ready_4", in_ready, 1);
        end
        N = 8'd2;
        for (int k = 7; k <= 12; k++) begin
            cyc();
            chk($sformatf("nchg_ready_%0d", k), in_ready, (k % 2) == 0);
        end
        N = 8'd0;
        cyc();
        chk("n0_ready_13", in_ready, 0);
        for (int k = 14; k <= 18; k++) begin
            cyc();
            chk($sformatf("n0_ready_%0d", k), in_ready, 1);
        end

        // Saturation on the GAIN_SHIFT=0 instance
        N = 8'd4;
        RST = 1'b1;
        cyc();
        RST = 1'b0; I_IN_s = 12'sd2047; Q_IN_s = -12'sd2048;
        repeat (20) cyc();
        chk("sat_i_pos", I_OUT_s, 2047);
        chk("sat_q_neg", Q_OUT_s, -2048);
        chk("sat_out_valid", out_valid_s, 1);
        chk("sat_underflow", underflow_s, 0);
        I_IN_s = -12'sd2048;
        repeat (30) cyc();
        chk("sat_i_neg", I_OUT_s, -2048);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
